// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the in-order MIPS pipeline: a shift-register
// scoreboard of in-flight writers (E..W) driving stall and forward selects, plus a HI/LO busy counter.
module hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int T_W      = 2,
  parameter int SEL_W    = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_d,
  input  logic [ADDR_W-1:0] rt_d,
  input  logic [T_W-1:0]    tuse_rs_d,
  input  logic [T_W-1:0]    tuse_rt_d,
  input  logic              wr_d,
  input  logic [ADDR_W-1:0] dst_d,
  input  logic [T_W-1:0]    tnew_d,
  input  logic              md_start_d,
  input  logic              md_div_d,
  input  logic              hilo_use_d,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_d,
  output logic [SEL_W-1:0]  fwd_rt_d,
  output logic [SEL_W-1:0]  fwd_rs_e,
  output logic [SEL_W-1:0]  fwd_rt_e,
  output logic [SEL_W-1:0]  fwd_rt_m,
  output logic              md_busy
);

  // Scoreboard entry k is the instruction currently k stages past D (1=E, 2=M, 3=W, ...).
  logic              vld_p  [1:STAGES];
  logic [ADDR_W-1:0] dst_p  [1:STAGES];
  logic [T_W-1:0]    tnew_p [1:STAGES];
  logic [ADDR_W-1:0] rs_p   [1:STAGES];
  logic [ADDR_W-1:0] rt_p   [1:STAGES];

  logic [CNT_W-1:0]  mdCnt;

  logic [STAGES:1] hitRsD, hitRtD, lateRsD, lateRtD, rdy;
  logic [STAGES:1] hitRsE, hitRtE, hitRtM;
  logic            stallRs, stallRt, stallHilo;

  function automatic logic [T_W-1:0] satDec(input logic [T_W-1:0] t);
    return (t == '0) ? t : t - T_W'(1);
  endfunction

  // Youngest matching producer at or beyond stage lo wins; it forwards only if already ready.
  function automatic logic [SEL_W-1:0] pickFwd(input logic [STAGES:1] hit,
                                               input logic [STAGES:1] ready,
                                               input int              lo);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (k >= lo && hit[k]) sel = ready[k] ? SEL_W'(k) : '0;
    end
    return sel;
  endfunction

  always_comb begin
    hitRsD  = '0;
    hitRtD  = '0;
    lateRsD = '0;
    lateRtD = '0;
    rdy     = '0;
    hitRsE  = '0;
    hitRtE  = '0;
    hitRtM  = '0;
    for (int k = 1; k <= STAGES; k++) begin
      rdy[k]     = (tnew_p[k] == '0);
      hitRsD[k]  = vld_p[k] && (dst_p[k] == rs_d) && (rs_d != '0);
      hitRtD[k]  = vld_p[k] && (dst_p[k] == rt_d) && (rt_d != '0);
      lateRsD[k] = (tnew_p[k] > tuse_rs_d);
      lateRtD[k] = (tnew_p[k] > tuse_rt_d);
      hitRsE[k]  = vld_p[k] && (dst_p[k] == rs_p[1]) && (rs_p[1] != '0);
      hitRtE[k]  = vld_p[k] && (dst_p[k] == rt_p[1]) && (rt_p[1] != '0);
      hitRtM[k]  = vld_p[k] && (dst_p[k] == rt_p[2]) && (rt_p[2] != '0);
    end
  end

  assign md_busy   = (mdCnt != '0);
  assign stallRs   = |(hitRsD & lateRsD);
  assign stallRt   = |(hitRtD & lateRtD);
  assign stallHilo = hilo_use_d && md_busy;
  assign stall     = stallRs || stallRt || stallHilo;

  // D consumers see no forwarding while held; E and M consumers always do.
  assign fwd_rs_d = stall ? '0 : pickFwd(hitRsD, rdy, 1);
  assign fwd_rt_d = stall ? '0 : pickFwd(hitRtD, rdy, 1);
  assign fwd_rs_e = pickFwd(hitRsE, rdy, 2);
  assign fwd_rt_e = pickFwd(hitRtE, rdy, 2);
  assign fwd_rt_m = pickFwd(hitRtM, rdy, 3);

  // ---- D -> E..W boundary: control (valid, busy counter) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) vld_p[k] <= 1'b0;
      mdCnt <= '0;
    end else begin
      vld_p[1] <= !stall && wr_d && (dst_d != '0);
      for (int k = 2; k <= STAGES; k++) vld_p[k] <= vld_p[k-1];
      if (md_start_d && !stall)
        mdCnt <= md_div_d ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (mdCnt != '0)
        mdCnt <= mdCnt - CNT_W'(1);
    end
  end

  // ---- D -> E..W boundary: entry payload; a bubble carries no registers ----
  always_ff @(posedge clk) begin
    if (stall) begin
      dst_p[1]  <= '0;
      tnew_p[1] <= '0;
      rs_p[1]   <= '0;
      rt_p[1]   <= '0;
    end else begin
      dst_p[1]  <= dst_d;
      tnew_p[1] <= tnew_d;
      rs_p[1]   <= rs_d;
      rt_p[1]   <= rt_d;
    end
    for (int k = 2; k <= STAGES; k++) begin
      dst_p[k]  <= dst_p[k-1];
      tnew_p[k] <= satDec(tnew_p[k-1]);
      rs_p[k]   <= rs_p[k-1];
      rt_p[k]   <= rt_p[k-1];
    end
  end

endmodule
